// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a strobe-handshake register target.
// One access at a time: IDLE -> WAIT (target request held) -> DONE (one-cycle done pulse).
module reg_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,

    input  logic                  i_m0_req,
    input  logic                  i_m0_wr,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    output logic                  o_m0_done,

    input  logic                  i_m1_req,
    input  logic                  i_m1_wr,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    output logic                  o_m1_done,

    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_err,
    output logic [1:0]            o_grant,

    output logic [ADDR_WIDTH-1:0] o_reg_address,
    output logic                  o_reg_in_rdy,
    input  logic                  i_reg_in_ack_stb,
    output logic [DATA_WIDTH-1:0] o_reg_in_data,
    output logic                  o_reg_out_req,
    input  logic                  i_reg_out_rdy_stb,
    input  logic [DATA_WIDTH-1:0] i_reg_out_data,
    input  logic                  i_reg_invalid_addr,

    output logic [1:0]            o_dbg_state
);

    // Handshake: a requester raises i_mN_req and holds it (with wr/addr/wdata stable)
    // until it samples o_mN_done high; the target sees o_reg_in_rdy / o_reg_out_req as
    // levels and answers with a single-cycle strobe that ends the access.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_t                r_state;
    logic [1:0]            r_grant;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_in_rdy;
    logic                  r_out_req;
    logic [1:0]            r_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [7:0]            r_cnt;
    logic                  r_last_m1;

    state_t                w_nxt_state;
    logic [1:0]            w_nxt_grant;
    logic                  w_nxt_wr;
    logic [ADDR_WIDTH-1:0] w_nxt_addr;
    logic [DATA_WIDTH-1:0] w_nxt_wdata;
    logic                  w_nxt_in_rdy;
    logic                  w_nxt_out_req;
    logic [1:0]            w_nxt_done;
    logic [DATA_WIDTH-1:0] w_nxt_rdata;
    logic                  w_nxt_err;
    logic [7:0]            w_nxt_cnt;
    logic                  w_nxt_last_m1;

    logic                  w_pick_m1;
    logic                  w_match;
    logic [7:0]            w_cnt_inc;
    logic                  w_timeout;

    // On a tie the requester that did not win last time gets the bus.
    assign w_pick_m1 = i_m1_req && (!i_m0_req || !r_last_m1);
    assign w_match   = r_wr ? i_reg_in_ack_stb : i_reg_out_rdy_stb;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == TIMEOUT_LIM);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_grant   = r_grant;
        w_nxt_wr      = r_wr;
        w_nxt_addr    = r_addr;
        w_nxt_wdata   = r_wdata;
        w_nxt_in_rdy  = r_in_rdy;
        w_nxt_out_req = r_out_req;
        w_nxt_done    = 2'b00;
        w_nxt_rdata   = r_rdata;
        w_nxt_err     = r_err;
        w_nxt_cnt     = r_cnt;
        w_nxt_last_m1 = r_last_m1;

        case (r_state)
            ST_IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    w_nxt_state   = ST_WAIT;
                    w_nxt_cnt     = 8'd0;
                    w_nxt_last_m1 = w_pick_m1;
                    if (w_pick_m1) begin
                        w_nxt_grant = 2'b10;
                        w_nxt_wr    = i_m1_wr;
                        w_nxt_addr  = i_m1_addr;
                        w_nxt_wdata = i_m1_wdata;
                    end else begin
                        w_nxt_grant = 2'b01;
                        w_nxt_wr    = i_m0_wr;
                        w_nxt_addr  = i_m0_addr;
                        w_nxt_wdata = i_m0_wdata;
                    end
                    w_nxt_in_rdy  = w_pick_m1 ? i_m1_wr : i_m0_wr;
                    w_nxt_out_req = w_pick_m1 ? !i_m1_wr : !i_m0_wr;
                end
            end

            ST_WAIT: begin
                // A matching strobe on the timeout cycle still completes normally.
                if (w_match) begin
                    w_nxt_state   = ST_DONE;
                    w_nxt_in_rdy  = 1'b0;
                    w_nxt_out_req = 1'b0;
                    w_nxt_done    = r_grant;
                    w_nxt_err     = i_reg_invalid_addr;
                    w_nxt_rdata   = r_wr ? '0 : i_reg_out_data;
                end else if (w_timeout) begin
                    w_nxt_state   = ST_DONE;
                    w_nxt_in_rdy  = 1'b0;
                    w_nxt_out_req = 1'b0;
                    w_nxt_done    = r_grant;
                    w_nxt_err     = 1'b1;
                    w_nxt_rdata   = '0;
                end else begin
                    w_nxt_cnt = w_cnt_inc;
                end
            end

            ST_DONE: begin
                w_nxt_state = ST_IDLE;
                w_nxt_grant = 2'b00;
                w_nxt_rdata = '0;
                w_nxt_err   = 1'b0;
            end

            default: begin
                w_nxt_state   = ST_IDLE;
                w_nxt_grant   = 2'b00;
                w_nxt_in_rdy  = 1'b0;
                w_nxt_out_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'b00;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_in_rdy  <= 1'b0;
            r_out_req <= 1'b0;
            r_done    <= 2'b00;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= 8'd0;
            r_last_m1 <= 1'b1;
        end else begin
            r_state   <= w_nxt_state;
            r_grant   <= w_nxt_grant;
            r_wr      <= w_nxt_wr;
            r_addr    <= w_nxt_addr;
            r_wdata   <= w_nxt_wdata;
            r_in_rdy  <= w_nxt_in_rdy;
            r_out_req <= w_nxt_out_req;
            r_done    <= w_nxt_done;
            r_rdata   <= w_nxt_rdata;
            r_err     <= w_nxt_err;
            r_cnt     <= w_nxt_cnt;
            r_last_m1 <= w_nxt_last_m1;
        end
    end

    assign o_m0_done     = r_done[0];
    assign o_m1_done     = r_done[1];
    assign o_rdata       = r_rdata;
    assign o_err         = r_err;
    assign o_grant       = r_grant;
    assign o_reg_address = r_addr;
    assign o_reg_in_rdy  = r_in_rdy;
    assign o_reg_in_data = r_wdata;
    assign o_reg_out_req = r_out_req;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter (TIMEOUT = 4): target responder tasks,
// a done-pulse scoreboard fed from an expected queue, and a final report.
module tb_reg_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_done, m1_done;
    logic [DW-1:0] rdata;
    logic          err;
    logic [1:0]    grant;
    logic [AW-1:0] reg_address;
    logic          reg_in_rdy, reg_out_req;
    logic          in_ack_stb, out_rdy_stb, invalid_addr;
    logic [DW-1:0] reg_in_data, reg_out_data;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry: {port (0 = m0, 1 = m1), err, rdata}
    logic [DW+1:0] exp_q[$];

    reg_bus_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .i_axi_clk         (clk),
        .i_axi_rst         (rst_n),
        .i_m0_req          (m0_req),
        .i_m0_wr           (m0_wr),
        .i_m0_addr         (m0_addr),
        .i_m0_wdata        (m0_wdata),
        .o_m0_done         (m0_done),
        .i_m1_req          (m1_req),
        .i_m1_wr           (m1_wr),
        .i_m1_addr         (m1_addr),
        .i_m1_wdata        (m1_wdata),
        .o_m1_done         (m1_done),
        .o_rdata           (rdata),
        .o_err             (err),
        .o_grant           (grant),
        .o_reg_address     (reg_address),
        .o_reg_in_rdy      (reg_in_rdy),
        .i_reg_in_ack_stb  (in_ack_stb),
        .o_reg_in_data     (reg_in_data),
        .o_reg_out_req     (reg_out_req),
        .i_reg_out_rdy_stb (out_rdy_stb),
        .i_reg_out_data    (reg_out_data),
        .i_reg_invalid_addr(invalid_addr),
        .o_dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (time %0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        logic [DW+1:0] e;
        if (m0_done || m1_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {m1_done, m0_done}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("done_port", {m1_done, m0_done}, e[DW+1] ? 2'b10 : 2'b01);
                check("done_err", err, e[DW]);
                check("done_rdata", rdata, e[DW-1:0]);
            end
        end
    end

    task automatic idle_check(input string tag);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_done"}, {m1_done, m0_done}, 2'b00);
        check({tag, "_rdy_req"}, {reg_in_rdy, reg_out_req}, 2'b00);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_state"}, dbg_state, 2'd0);
    endtask

    // ---------------- drivers ----------------
    task automatic raise(input int m, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        if (m == 0) begin
            m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // Serves the next granted access as the target. delay = WAIT cycle in which the
    // matching strobe is given (0 = never); noise = non-matching strobe in WAIT cycle 1.
    task automatic serve(input int m, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int delay, input logic noise,
                         input logic [DW-1:0] tdata, input logic inv,
                         input logic exp_err, input logic [DW-1:0] exp_rdata,
                         input int exp_wait);
        int  waits;
        bit  seen;
        waits = 0;
        seen  = 0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (grant != 2'b00) break;
            @(negedge clk);
        end
        check("grant", grant, (m == 1) ? 2'b10 : 2'b01);
        check("reg_address", reg_address, addr);
        if (wr) check("reg_in_data", reg_in_data, wdata);
        exp_q.push_back({(m == 1), exp_err, exp_rdata});
        for (int c = 1; c <= 12; c++) begin
            if (m0_done || m1_done) begin
                seen = 1;
                break;
            end
            check("wait_state", dbg_state, 2'd1);
            check("rdy_req_dir", {reg_in_rdy, reg_out_req}, wr ? 2'b10 : 2'b01);
            check("grant_hold", grant, (m == 1) ? 2'b10 : 2'b01);
            waits++;
            if (noise && c == 1 && delay != 1) begin
                if (wr) begin
                    out_rdy_stb = 1'b1; reg_out_data = 32'hFFFF_FFFF;
                end else begin
                    in_ack_stb = 1'b1;
                end
                invalid_addr = 1'b1;
            end
            if (c == delay) begin
                if (wr) begin
                    in_ack_stb = 1'b1;
                end else begin
                    out_rdy_stb = 1'b1; reg_out_data = tdata;
                end
                invalid_addr = inv;
            end
            @(negedge clk);
            in_ack_stb   = 1'b0;
            out_rdy_stb  = 1'b0;
            invalid_addr = 1'b0;
            reg_out_data = '0;
        end
        check("done_seen", seen, 1);
        check("wait_cycles", waits, exp_wait);
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
        in_ack_stb = 0; out_rdy_stb = 0; invalid_addr = 0; reg_out_data = '0;

        repeat (3) @(negedge clk);
        idle_check("reset");
        check("reset_addr", reg_address, 0);
        check("reset_in_data", reg_in_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write m0: ack two cycles after rdy rises, plus an ignored read strobe.
        raise(0, 1'b1, 16'h0000, 32'hDEAD_BEEF);
        serve(0, 1'b1, 16'h0000, 32'hDEAD_BEEF, 3, 1'b1, '0, 1'b0, 1'b0, '0, 3);

        // Read m1: data on the first WAIT cycle -> done at cycle 2.
        raise(1, 1'b0, 16'h0004, '0);
        serve(1, 1'b0, 16'h0004, '0, 1, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 32'h1000_0000, 1);

        // Contention rounds: tie with last = m1 -> m0, then m1 served.
        for (int r = 0; r < 2; r++) begin
            raise(0, 1'b0, 16'h0010, '0);
            raise(1, 1'b1, 16'h0014, 32'hA5A5_0000 + r);
            serve(0, 1'b0, 16'h0010, '0, 2, 1'b1, 32'h1234_5670 + r, 1'b0, 1'b0,
                  32'h1234_5670 + r, 2);
            serve(1, 1'b1, 16'h0014, 32'hA5A5_0000 + r, 1, 1'b0, '0, 1'b0, 1'b0, '0, 1);
        end

        // Invalid address on an m0 read.
        raise(0, 1'b0, 16'h0008, '0);
        serve(0, 1'b0, 16'h0008, '0, 1, 1'b0, '0, 1'b1, 1'b1, '0, 1);

        // Tie with last = m0 -> m1 wins.
        raise(0, 1'b1, 16'h0018, 32'h0000_5555);
        raise(1, 1'b0, 16'h001C, '0);
        serve(1, 1'b0, 16'h001C, '0, 2, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 2);
        serve(0, 1'b1, 16'h0018, 32'h0000_5555, 1, 1'b0, '0, 1'b0, 1'b0, '0, 1);

        // Timeouts: write with no ack, read with no data, ack in the last WAIT cycle.
        raise(0, 1'b1, 16'h0020, 32'h0000_1111);
        serve(0, 1'b1, 16'h0020, 32'h0000_1111, 0, 1'b0, '0, 1'b0, 1'b1, '0, TO);
        raise(1, 1'b0, 16'h0022, '0);
        serve(1, 1'b0, 16'h0022, '0, 0, 1'b1, '0, 1'b0, 1'b1, '0, TO);
        raise(0, 1'b1, 16'h0024, 32'h0000_2222);
        serve(0, 1'b1, 16'h0024, 32'h0000_2222, TO, 1'b0, '0, 1'b0, 1'b0, '0, TO);

        // Strobes while idle change nothing.
        @(negedge clk);
        in_ack_stb = 1'b1; out_rdy_stb = 1'b1; invalid_addr = 1'b1;
        reg_out_data = 32'hFFFF_FFFF;
        @(negedge clk);
        in_ack_stb = 1'b0; out_rdy_stb = 1'b0; invalid_addr = 1'b0; reg_out_data = '0;
        idle_check("idle_stb");
        check("idle_stb_addr", reg_address, 16'h0024);
        check("idle_stb_in_data", reg_in_data, 32'h0000_2222);

        // Reset in the middle of a write: everything clears asynchronously, no done.
        raise(0, 1'b1, 16'h0040, 32'h0000_7777);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_rdy", reg_in_rdy, 1);
        #2 rst_n = 1'b0;
        #1;
        idle_check("mid_rst");
        check("mid_rst_addr", reg_address, 0);
        check("mid_rst_in_data", reg_in_data, 0);
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
        idle_check("in_rst");
        rst_n = 1'b1;
        raise(1, 1'b0, 16'h0030, '0);
        serve(1, 1'b0, 16'h0030, '0, 2, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 32'hCAFE_0001, 2);

        repeat (3) @(negedge clk);
        idle_check("final");
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_WIDTH, default 16, register address width.
- DATA_WIDTH, default 32, register data width.
- TIMEOUT, default 255, maximum cycles to wait for a target strobe; legal range 1..255.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_axi_clk  in  1  single clock; all logic on its rising edge.
- i_axi_rst  in  1  reset, asynchronous, active-low.
- i_m0_req  in  1  requester 0 access request; level, held until o_m0_done.
- i_m0_wr  in  1  requester 0 direction: 1 = write, 0 = read.
- i_m0_addr  in  ADDR_WIDTH  requester 0 register address.
- i_m0_wdata  in  DATA_WIDTH  requester 0 write data.
- o_m0_done  out  1  requester 0 completion pulse, one cycle.
- i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata, o_m1_done  same as requester 0, for requester 1.
- o_rdata  out  DATA_WIDTH  read data; valid only while a done pulse is high.
- o_err  out  1  error flag (invalid address or timeout); valid only while a done pulse is high.
- o_grant  out  2  one-hot owner of the current access; 0 when idle.
- o_reg_address  out  ADDR_WIDTH  target register address.
- o_reg_in_rdy  out  1  write data pending to the target; level.
- i_reg_in_ack_stb  in  1  target has consumed the write; one-cycle strobe.
- o_reg_in_data  out  DATA_WIDTH  write data to the target.
- o_reg_out_req  out  1  read pending at the target; level.
- i_reg_out_rdy_stb  in  1  target read data valid; one-cycle strobe.
- i_reg_out_data  in  DATA_WIDTH  target read data.
- i_reg_invalid_addr  in  1  target address error; sampled in the same cycle as either target strobe.

Function
REQ-003 The block SHALL implement a state machine with three states: IDLE, WAIT and DONE.

REQ-004 IDLE, when any i_mN_req is high:
- Select a requester by round-robin (REQ-005).
- Latch that requester's address, wdata and wr into o_reg_address, o_reg_in_data and the direction bit.
- Set o_grant.
- Clear the timeout counter.
- Go to WAIT.

REQ-005 Arbitration:
- When only one requester is requesting, that requester wins.
- When both request in the same IDLE cycle, the requester not granted last wins.
- The last-grant record resets to requester 1, so requester 0 wins the first tie.

REQ-006 WAIT:
- If direction = write, o_reg_in_rdy SHALL be 1 throughout WAIT.
- If direction = read, o_reg_out_req SHALL be 1 throughout WAIT.
- o_reg_in_rdy and o_reg_out_req SHALL never be high in the same cycle.

REQ-007 In WAIT, the matching strobe ends the access: i_reg_in_ack_stb for a write, i_reg_out_rdy_stb for a read.
- Capture i_reg_invalid_addr into the error register.
- For a read, capture i_reg_out_data into o_rdata.
- Deassert the target request and go to DONE.

REQ-008 In WAIT, the non-matching strobe SHALL be ignored.

REQ-009 Timeout:
- The counter increments once per WAIT cycle.
- If it reaches TIMEOUT with no matching strobe, the block SHALL go to DONE with o_err = 1 and o_rdata = 0.
- A matching strobe in the same cycle as the timeout wins over the timeout.

REQ-010 DONE lasts exactly one cycle:
- o_mN_done = 1 for the granted requester only, with o_rdata and o_err valid.
- Then o_grant returns to 0 and the state returns to IDLE.

REQ-011 A requester SHALL drop i_mN_req on the clock edge at which it samples o_mN_done high. Requests are re-sampled only in IDLE.

REQ-012 Latency: request seen in IDLE at cycle 0 gives WAIT at cycle 1. Strobe at cycle k≥1 gives done at cycle k+1. Minimum request-to-done latency is 2 cycles.

REQ-013 Target strobes arriving in IDLE or DONE SHALL be ignored and SHALL NOT change any output.

REQ-014 For write accesses, o_rdata SHALL be 0 during the done pulse.

Reset
REQ-015 Asserting i_axi_rst low SHALL immediately and asynchronously do all of the following, including in the middle of an access:
- Force state IDLE.
- Clear all outputs to 0: o_reg_*, o_grant, o_mN_done, o_rdata, o_err.
- Clear the timeout counter.
- Set the last-grant record to requester 1.
No done pulse SHALL be produced for an access aborted by reset.

REQ-016 After reset release, the first rising edge SHALL evaluate requests normally.

Verification
REQ-017 Write: m0 writes addr 0x0000, data 0xDEADBEEF, and the target acks 2 cycles after o_reg_in_rdy rises -> o_reg_in_data = 0xDEADBEEF, o_m0_done pulses one cycle later, o_err = 0.

REQ-018 Read: m1 reads addr 0x0004, and the target returns 0x10000000 with i_reg_out_rdy_stb on the first WAIT cycle -> o_m1_done at cycle 2, o_rdata = 0x10000000, o_err = 0.

REQ-019 Contention: m0 and m1 request in the same cycle, repeatedly, out of reset -> grants alternate m0, m1, m0, m1, with each done on the matching port only.

REQ-020 Invalid address: m0 reads addr 0x0008, and the target strobes with i_reg_invalid_addr = 1 -> o_m0_done with o_err = 1.

REQ-021 Timeout: TIMEOUT = 4, m0 write with no ack -> o_reg_in_rdy is high for exactly 4 cycles, then o_m0_done with o_err = 1. A second run with the ack arriving in the 4th WAIT cycle -> o_err = 0.

REQ-022 Reset mid-access: i_axi_rst driven low during WAIT -> all outputs 0 asynchronously and no done pulse. After release, a fresh m1 request completes normally.
